exp_accel_param: RTL and testbench

Parametrised successor to the fixed 16-bit exponential accelerator. Computes e^x, or e^-x in negate mode, for an unsigned fraction x in [0,1). It evaluates a truncated Taylor series by iterative Horner evaluation, one term per clock. It sits beside the existing accelerator as a drop-in core with configurable input width, output precision and term count, and adds a busy/level-start handshake.

---
 rtl/exp_accel_param.sv | 137 +++++++++++++
 tb/tb_exp_accel_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_accel_param.sv
// Parametrised e^x / e^-x accelerator for an unsigned fraction x in [0,1).
// Horner-form truncated Taylor series, one term per clock, result in 2.FW fixed point.
module exp_accel_param #(
  parameter int XW    = 16,
  parameter int FW    = 16,
  parameter int TERMS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          neg,
  input  logic [XW-1:0] x,
  output logic          busy,
  output logic          done,
  output logic [1:0]    intpart,
  output logic [FW-1:0] fracpart
);

  localparam int KW    = $clog2(TERMS);
  localparam int AW    = FW + 2;
  localparam int PW    = XW + AW;
  localparam int QFULL = AW + FW + 1;
  localparam logic [AW-1:0] ONE    = AW'(1) << FW;
  localparam logic [KW-1:0] K_INIT = KW'(TERMS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0]    acc;
  logic [KW-1:0]    k;
  logic [XW-1:0]    x_r;
  logic             neg_r;
  logic             load;
  logic             step;
  logic             last_term;
  logic [PW-1:0]    prod_p;
  logic [AW-1:0]    p;
  logic [QFULL-1:0] prod_q;
  logic [AW-1:0]    q;
  logic [AW-1:0]    acc_step;
  logic             unused_bits;

  // Reciprocal table R[k] = floor(2^FW / k); entry 0 is never selected in CALC.
  function automatic logic [FW:0] recip(input int kk);
    logic [63:0] num;
    num = 64'd1 << FW;
    return (FW+1)'(num / 64'(kk));
  endfunction

  logic [FW:0] r_tab [TERMS];

  for (genvar i = 0; i < TERMS; i++) begin : g_recip
    assign r_tab[i] = recip((i == 0) ? 1 : i);
  end

  // One Horner step: acc' = 1 +/- (x * acc) / k, both products truncated.
  always_comb begin
    prod_p    = PW'(x_r) * PW'(acc);
    p         = prod_p[XW +: AW];
    prod_q    = QFULL'(p) * QFULL'(r_tab[k]);
    q         = prod_q[FW +: AW];
    acc_step  = neg_r ? (ONE - q) : (ONE + q);
    last_term = (k == KW'(1));
  end

  assign unused_bits = ^{prod_p[XW-1:0], prod_q[FW-1:0], prod_q[QFULL-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_term) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result registers load on the edge that enters DONE so they are valid with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      k        <= '0;
      x_r      <= '0;
      neg_r    <= 1'b0;
      intpart  <= '0;
      fracpart <= '0;
    end else if (load) begin
      x_r   <= x;
      neg_r <= neg;
      acc   <= ONE;
      k     <= K_INIT;
    end else if (step) begin
      acc <= acc_step;
      k   <= k - KW'(1);
      if (last_term) begin
        intpart  <= acc_step[AW-1:FW];
        fracpart <= acc_step[FW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_exp_accel_param.sv
// Directed self-checking bench for exp_accel_param: default core plus an XW=8/FW=24/TERMS=12 core.
module tb_exp_accel_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        neg;
  logic [15:0] x;
  logic        busy;
  logic        done;
  logic [1:0]  intpart;
  logic [15:0] fracpart;

  logic        start_w;
  logic        neg_w;
  logic [7:0]  x_w;
  logic        busy_w;
  logic        done_w;
  logic [1:0]  intpart_w;
  logic [23:0] fracpart_w;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exp_accel_param #(.XW(16), .FW(16), .TERMS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .neg(neg), .x(x),
    .busy(busy), .done(done), .intpart(intpart), .fracpart(fracpart)
  );

  exp_accel_param #(.XW(8), .FW(24), .TERMS(12)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .neg(neg_w), .x(x_w),
    .busy(busy_w), .done(done_w), .intpart(intpart_w), .fracpart(fracpart_w)
  );

  // Runs one operation on the default core from IDLE; returns cycles-to-done and the result.
  task automatic do_op(input logic [15:0] xv, input logic nv,
                       output int cycles, output logic [1:0] ip, output logic [15:0] fp);
    x = xv;
    neg = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    ip = intpart;
    fp = fracpart;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0 || intpart !== 2'd0 || fracpart !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_default: busy=%b done=%b int=%0d frac=%h, want 0 0 0 0000",
               busy, done, intpart, fracpart);
    end
    asserts++;
    if (busy_w !== 1'b0 || done_w !== 1'b0 || intpart_w !== 2'd0 || fracpart_w !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_wide: busy=%b done=%b int=%0d frac=%h, want 0 0 0 000000",
               busy_w, done_w, intpart_w, fracpart_w);
    end
    rst = 1'b0;
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_busy;
    logic exp_done;
    x = 16'h0000;
    neg = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      exp_busy = (c % 9) != 0;
      exp_done = (c % 9) == 8;
      asserts++;
      if (busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("[TB] FAIL b2b_handshake c=%0d: busy=%b done=%b, want %b %b",
                 c, busy, done, exp_busy, exp_done);
      end
      if (c == 8 || c == 17) begin
        asserts++;
        if (intpart !== 2'd1 || fracpart !== 16'h0000) begin
          failures++;
          $display("[TB] FAIL b2b_x0_result c=%0d: got %0d.%h, want 1.0000", c, intpart, fracpart);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pos_max();
    int cycles;
    logic [1:0] ip;
    logic [15:0] fp;
    int d;
    do_op(16'hFFFF, 1'b0, cycles, ip, fp);
    asserts++;
    if (cycles !== 8) begin
      failures++;
      $display("[TB] FAIL pos_max_latency: got %0d cycles, want 8", cycles);
    end
    d = int'(fp) - 32'hB7DF;
    if (d < 0) d = -d;
    asserts++;
    if (ip !== 2'd2 || d > 16) begin
      failures++;
      $display("[TB] FAIL pos_max_value: got %0d.%h, want 2.B7DF +/-16", ip, fp);
    end
  endtask

  task automatic test_half();
    int cycles;
    logic [1:0] ip;
    logic [15:0] fp;
    int d;
    do_op(16'h8000, 1'b0, cycles, ip, fp);
    d = int'(fp) - 32'hA612;
    if (d < 0) d = -d;
    asserts++;
    if (ip !== 2'd1 || d > 16) begin
      failures++;
      $display("[TB] FAIL half_pos_value: got %0d.%h, want 1.A612 +/-16", ip, fp);
    end
    do_op(16'h8000, 1'b1, cycles, ip, fp);
    d = int'(fp) - 32'h9B46;
    if (d < 0) d = -d;
    asserts++;
    if (ip !== 2'd0 || d > 16) begin
      failures++;
      $display("[TB] FAIL half_neg_value: got %0d.%h, want 0.9B46 +/-16", ip, fp);
    end
    asserts++;
    if (cycles !== 8) begin
      failures++;
      $display("[TB] FAIL half_neg_latency: got %0d cycles, want 8", cycles);
    end
  endtask

  task automatic test_zero_neg();
    int cycles;
    logic [1:0] ip;
    logic [15:0] fp;
    do_op(16'h0000, 1'b1, cycles, ip, fp);
    asserts++;
    if (ip !== 2'd1 || fp !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL zero_neg_value: got %0d.%h, want 1.0000", ip, fp);
    end
  endtask

  // Previous result is exactly 1.0000, so holding can be checked exactly during the run.
  task automatic test_latched_operands();
    int cycles;
    int d;
    x = 16'h8000;
    neg = 1'b0;
    start = 1'b1;
    @(negedge clk);
    x = 16'hFFFF;
    neg = 1'b1;
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      asserts++;
      if (intpart !== 2'd1 || fracpart !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL latched_hold c=%0d: got %0d.%h, want 1.0000", cycles, intpart, fracpart);
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    asserts++;
    if (cycles !== 8) begin
      failures++;
      $display("[TB] FAIL latched_latency: got %0d cycles, want 8", cycles);
    end
    d = int'(fracpart) - 32'hA612;
    if (d < 0) d = -d;
    asserts++;
    if (intpart !== 2'd1 || d > 16) begin
      failures++;
      $display("[TB] FAIL latched_value: got %0d.%h, want 1.A612 +/-16", intpart, fracpart);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cycles;
    int bad;
    logic [1:0] ip;
    logic [15:0] fp;
    int d;
    x = 16'hFFFF;
    neg = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0 || intpart !== 2'd0 || fracpart !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL abort_outputs: busy=%b done=%b int=%0d frac=%h, want 0 0 0 0000",
               busy, done, intpart, fracpart);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    asserts++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: %0d cycles with busy/done high, want 0", bad);
    end
    do_op(16'h8000, 1'b1, cycles, ip, fp);
    d = int'(fp) - 32'h9B46;
    if (d < 0) d = -d;
    asserts++;
    if (cycles !== 8 || ip !== 2'd0 || d > 16) begin
      failures++;
      $display("[TB] FAIL abort_recovery: got %0d cycles %0d.%h, want 8 cycles 0.9B46 +/-16",
               cycles, ip, fp);
    end
  endtask

  task automatic test_param_sweep();
    int cycles;
    int busy_cnt;
    int d;
    x_w = 8'h80;
    neg_w = 1'b0;
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    cycles = 1;
    busy_cnt = (busy_w === 1'b1) ? 1 : 0;
    while (done_w !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy_w === 1'b1) busy_cnt++;
    end
    asserts++;
    if (cycles !== 12 || busy_cnt !== 12) begin
      failures++;
      $display("[TB] FAIL sweep_latency: done after %0d cycles, busy %0d, want 12 12", cycles, busy_cnt);
    end
    d = int'(fracpart_w) - 32'hA61298;
    if (d < 0) d = -d;
    asserts++;
    if (intpart_w !== 2'd1 || d > 16) begin
      failures++;
      $display("[TB] FAIL sweep_value: got %0d.%h, want 1.A61298 +/-16", intpart_w, fracpart_w);
    end
    @(negedge clk);
    asserts++;
    if (busy_w !== 1'b0 || done_w !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sweep_idle: busy=%b done=%b, want 0 0", busy_w, done_w);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    neg = 1'b0;
    x = 16'h0000;
    start_w = 1'b0;
    neg_w = 1'b0;
    x_w = 8'h00;
    $display("[TB] starting exp_accel_param bench");
    test_reset();
    test_back_to_back();
    test_pos_max();
    test_half();
    test_zero_neg();
    test_latched_operands();
    test_reset_abort();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
